sram_fifo_ctrl: RTL and testbench
=================================

SRAM_FIFO_CTRL -- requirements
Module: sram_fifo_ctrl

Interface
REQ-001 Parameter WIDTH, default 8, data word width; SHALL match the dual SRAM WIDTH.
REQ-002 Parameter DEPTH, default 8, entry count; SHALL be a power of two and match the SRAM DEPTH.
REQ-003 Parameter ADDR_WIDTH, default $clog2(DEPTH), pointer and address width.
REQ-004 clk  input  1  clock; all logic on the rising edge.
REQ-005 reset  input  1  reset, synchronous, active-high.
REQ-006 push  input  1  write request; push_data is accepted when push && !full.
REQ-007 push_data  input  WIDTH  word to enqueue.
REQ-008 pop  input  1  read request; a read is issued when pop && !empty.
REQ-009 pop_valid  output  1  pop_data is valid this cycle.
REQ-010 pop_data  output  WIDTH  dequeued word, driven from sram_data_out_b.
REQ-011 full, empty  output  1 each  occupancy flags.
REQ-012 count  output  ADDR_WIDTH+1  current occupancy, 0..DEPTH.
REQ-013 overflow, underflow  output  1 each  one-cycle error pulses.
REQ-014 sram_chip_sel  output  1  SRAM chip select.
REQ-015 sram_read_ena_a, sram_read_ena_b  output  1 each  SRAM port read enables.
REQ-016 sram_address_a, sram_address_b  output  ADDR_WIDTH each  SRAM port addresses.
REQ-017 sram_data_in_a, sram_data_in_b  output  WIDTH each  SRAM write data.
REQ-018 sram_data_out_b  input  WIDTH  SRAM port B read data, 1-cycle latency.

Function
REQ-019 Port A is the write port; port B is the read port; sram_data_in_b is tied to 0 and sram_read_ena_b is tied to 1.
REQ-020 sram_chip_sel is 0 during reset and the cycle after it, and 1 at all other times.
REQ-021 sram_read_ena_a is 0 only on an accepted push, so an idle port A performs a harmless read rather than a write.
REQ-022 On an accepted push, sram_address_a = wr_ptr and sram_data_in_a = push_data; wr_ptr increments modulo DEPTH.
REQ-023 sram_address_b is always rd_ptr; on an issued pop, rd_ptr increments modulo DEPTH.
REQ-024 pop_valid is asserted exactly 1 cycle after an issued pop, and pop_data equals sram_data_out_b in that cycle.
REQ-025 count changes as follows: +1 on push only, -1 on pop only, unchanged on simultaneous push and pop.
REQ-026 full = (count == DEPTH); empty = (count == 0); both are registered and consistent with count.
REQ-027 A push while full is dropped and pulses overflow, even if pop is high in the same cycle.
REQ-028 A pop while empty is ignored and pulses underflow, even if push is high in the same cycle; there is no read-through.
REQ-029 A simultaneous push and pop on a non-empty, non-full FIFO are both accepted; wr_ptr != rd_ptr by construction, so there is no same-address collision.
REQ-030 Pointers wrap from DEPTH-1 to 0 with no change in flags.

Reset
REQ-031 On reset: wr_ptr = 0, rd_ptr = 0, count = 0, empty = 1, full = 0, pop_valid = 0, overflow = 0, underflow = 0, sram_chip_sel = 0.
REQ-032 Reset asserted mid-operation discards in-flight reads: pop_valid is 0 in the cycle following reset.
REQ-033 pop_data is unspecified while pop_valid = 0.

Structure
REQ-034 The shared package fifo_pkg holds the WIDTH/DEPTH defaults and the addr_t and count_t typedefs.
REQ-035 One sub-module, fifo_ptr, SHALL implement a single wrapping pointer with enable; it is instantiated twice.
REQ-036 The block is a pure controller with no storage; the SRAM is instantiated alongside it at the wrapper level.

Verification
REQ-037 Scenario 1: push 0x11, 0x22, 0x33 on consecutive cycles, then pop x3 -> pop_valid pulses with 0x11, 0x22, 0x33 one cycle after each pop; count returns to 0.
REQ-038 Scenario 2: push 8 words while pop is idle -> full=1 and count=8; a 9th push of 0xAA pulses overflow and is never popped.
REQ-039 Scenario 3: pop on empty with push of 0x5C in the same cycle -> underflow pulses and there is no pop_valid; the next pop returns 0x5C.
REQ-040 Scenario 4: at count=4, assert push and pop for 10 cycles -> count stays 4, pointers wrap, and data order is preserved.
REQ-041 Scenario 5: assert reset on the cycle after a pop is issued -> pop_valid=0, count=0, empty=1; sram_chip_sel=0 during reset and the following cycle.
REQ-042 Scenario 6: a scoreboard checks that port A never writes (chip_sel && !read_ena_a) unless push && !full.

Source files
------------

// File: rtl/fifo_pkg.sv
// fifo_pkg: shared defaults and helper types for the SRAM-backed FIFO
// controller.
//   FIFO_WIDTH / FIFO_DEPTH : default data width and entry count
//   addr_t                  : SRAM address / pointer type at the default depth
//   count_t                 : occupancy type at the default depth (0..DEPTH)
package fifo_pkg;

  localparam int FIFO_WIDTH      = 8;
  localparam int FIFO_DEPTH      = 8;
  localparam int FIFO_ADDR_WIDTH = $clog2(FIFO_DEPTH);

  typedef logic [FIFO_ADDR_WIDTH-1:0] addr_t;
  typedef logic [FIFO_ADDR_WIDTH:0]   count_t;

endpackage

// File: rtl/fifo_ptr.sv
// fifo_ptr: single wrapping pointer with enable.
//   clk   : clock, rising edge
//   reset : synchronous, active-high; clears the pointer to 0
//   en    : advance the pointer by one this cycle
//   ptr   : current pointer value, wraps from 2**ADDR_WIDTH-1 to 0
module fifo_ptr #(
  parameter int ADDR_WIDTH = 3
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  en,
  output logic [ADDR_WIDTH-1:0] ptr
);

  // Depth is a power of two, so natural overflow of the adder is the wrap.
  always_ff @(posedge clk) begin
    if (reset) begin
      ptr <= '0;
    end else if (en) begin
      ptr <= ptr + 1'b1;
    end
  end

endmodule

// File: rtl/sram_fifo_ctrl.sv
// sram_fifo_ctrl: FIFO controller driving an external dual-port SRAM.
// Port A of the SRAM is the write port, port B the read port. The block
// holds only pointers, occupancy and flags; the data lives in the SRAM.
//   clk, reset               : clock (rising edge), sync active-high reset
//   push, push_data          : enqueue request and word
//   pop                      : dequeue request
//   pop_valid, pop_data      : dequeued word, one cycle after an issued pop
//   full, empty, count       : registered occupancy state
//   overflow, underflow      : one-cycle error pulses (push when full,
//                              pop when empty)
//   sram_chip_sel            : SRAM chip select
//   sram_read_ena_a/_b       : SRAM read enables (low on A means write)
//   sram_address_a/_b        : SRAM addresses (A = write ptr, B = read ptr)
//   sram_data_in_a/_b        : SRAM write data (B never writes)
//   sram_data_out_b          : SRAM port B read data, 1-cycle latency
module sram_fifo_ctrl
  import fifo_pkg::*;
#(
  parameter int WIDTH      = FIFO_WIDTH,
  parameter int DEPTH      = FIFO_DEPTH,
  parameter int ADDR_WIDTH = $clog2(DEPTH)
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  push,
  input  logic [WIDTH-1:0]      push_data,
  input  logic                  pop,
  output logic                  pop_valid,
  output logic [WIDTH-1:0]      pop_data,
  output logic                  full,
  output logic                  empty,
  output logic [ADDR_WIDTH:0]   count,
  output logic                  overflow,
  output logic                  underflow,
  output logic                  sram_chip_sel,
  output logic                  sram_read_ena_a,
  output logic                  sram_read_ena_b,
  output logic [ADDR_WIDTH-1:0] sram_address_a,
  output logic [ADDR_WIDTH-1:0] sram_address_b,
  output logic [WIDTH-1:0]      sram_data_in_a,
  output logic [WIDTH-1:0]      sram_data_in_b,
  input  logic [WIDTH-1:0]      sram_data_out_b
);

  localparam logic [ADDR_WIDTH:0] DEPTH_C = (ADDR_WIDTH+1)'(DEPTH);

  logic [ADDR_WIDTH-1:0] wr_ptr;
  logic [ADDR_WIDTH-1:0] rd_ptr;
  logic                  chip_sel_p1;
  logic                  do_push_p0;
  logic                  do_pop_p0;
  logic [ADDR_WIDTH:0]   count_nxt;

  // Stage p0: request qualification and SRAM port drive (combinational).
  // chip_sel_p1 is cleared by reset and comes back one cycle after reset
  // drops; gating with reset makes the select low during reset as well.
  assign sram_chip_sel = chip_sel_p1 & ~reset;

  // Requests are only taken while the SRAM is selected, otherwise a push in
  // the post-reset cycle would advance wr_ptr without the word being stored.
  assign do_push_p0 = push & ~full  & sram_chip_sel;
  assign do_pop_p0  = pop  & ~empty & sram_chip_sel;

  assign sram_read_ena_a = ~do_push_p0;
  assign sram_address_a  = wr_ptr;
  assign sram_data_in_a  = push_data;

  assign sram_read_ena_b = 1'b1;
  assign sram_address_b  = rd_ptr;
  assign sram_data_in_b  = '0;

  assign pop_data = sram_data_out_b;

  always_comb begin
    count_nxt = count;
    unique case ({do_push_p0, do_pop_p0})
      2'b10:   count_nxt = count + 1'b1;
      2'b01:   count_nxt = count - 1'b1;
      default: count_nxt = count;
    endcase
  end

  fifo_ptr #(.ADDR_WIDTH(ADDR_WIDTH)) u_wr_ptr (
    .clk   (clk),
    .reset (reset),
    .en    (do_push_p0),
    .ptr   (wr_ptr)
  );

  fifo_ptr #(.ADDR_WIDTH(ADDR_WIDTH)) u_rd_ptr (
    .clk   (clk),
    .reset (reset),
    .en    (do_pop_p0),
    .ptr   (rd_ptr)
  );

  // Stage p1: registered occupancy, flags and read-valid. pop_valid lines up
  // with the SRAM's one-cycle read latency on port B; flags are derived from
  // the next count so they always agree with the registered count.
  always_ff @(posedge clk) begin
    if (reset) begin
      count       <= '0;
      full        <= 1'b0;
      empty       <= 1'b1;
      pop_valid   <= 1'b0;
      overflow    <= 1'b0;
      underflow   <= 1'b0;
      chip_sel_p1 <= 1'b0;
    end else begin
      count       <= count_nxt;
      full        <= (count_nxt == DEPTH_C);
      empty       <= (count_nxt == '0);
      pop_valid   <= do_pop_p0;
      overflow    <= push & full;
      underflow   <= pop & empty;
      chip_sel_p1 <= 1'b1;
    end
  end

endmodule

// File: tb/tb_sram_fifo_ctrl.sv
// Testbench for sram_fifo_ctrl: behavioural SRAM, queue-based reference
// model compared every cycle, plus directed scenarios with literal values.
module tb_sram_fifo_ctrl;
  import fifo_pkg::*;

  localparam int W  = 8;
  localparam int D  = 8;
  localparam int AW = 3;

  logic          clk;
  logic          reset;
  logic          push;
  logic [W-1:0]  push_data;
  logic          pop;
  logic          pop_valid;
  logic [W-1:0]  pop_data;
  logic          full;
  logic          empty;
  logic [AW:0]   count;
  logic          overflow;
  logic          underflow;
  logic          sram_chip_sel;
  logic          sram_read_ena_a;
  logic          sram_read_ena_b;
  logic [AW-1:0] sram_address_a;
  logic [AW-1:0] sram_address_b;
  logic [W-1:0]  sram_data_in_a;
  logic [W-1:0]  sram_data_in_b;
  logic [W-1:0]  sram_data_out_b;

  int total = 0;
  int bad   = 0;

  sram_fifo_ctrl #(.WIDTH(W), .DEPTH(D), .ADDR_WIDTH(AW)) dut (
    .clk             (clk),
    .reset           (reset),
    .push            (push),
    .push_data       (push_data),
    .pop             (pop),
    .pop_valid       (pop_valid),
    .pop_data        (pop_data),
    .full            (full),
    .empty           (empty),
    .count           (count),
    .overflow        (overflow),
    .underflow       (underflow),
    .sram_chip_sel   (sram_chip_sel),
    .sram_read_ena_a (sram_read_ena_a),
    .sram_read_ena_b (sram_read_ena_b),
    .sram_address_a  (sram_address_a),
    .sram_address_b  (sram_address_b),
    .sram_data_in_a  (sram_data_in_a),
    .sram_data_in_b  (sram_data_in_b),
    .sram_data_out_b (sram_data_out_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural dual-port SRAM: port A writes when its read enable is low,
  // port B reads with one cycle of latency.
  logic [W-1:0] mem [D];
  always @(posedge clk) begin
    if (sram_chip_sel) begin
      if (!sram_read_ena_a) mem[sram_address_a] <= sram_data_in_a;
      if (sram_read_ena_b)  sram_data_out_b <= mem[sram_address_b];
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Reference model: a queue of stored words plus a "selected" flag that is
  // false for the cycle after reset. Checked every cycle #1 after the edge.
  logic [W-1:0] mq [$];
  bit           started = 0;
  bit           m_cs    = 0;
  addr_t        m_wr    = '0;
  addr_t        m_rd    = '0;

  always @(posedge clk) begin
    logic         p, q, r, ap, aq, ov, uf, pv, wen;
    logic [W-1:0] pd, ed;
    p = push; q = pop; r = reset; pd = push_data;
    ed = '0; pv = 0; ov = 0; uf = 0;
    if (started && !r) begin
      chk("read_ena_b", sram_read_ena_b, 1);
      chk("data_in_b", sram_data_in_b, 0);
      chk("address_b", sram_address_b, m_rd);
      wen = sram_chip_sel && !sram_read_ena_a;
      chk("port_a_write_only_on_accepted_push", wen, p && (mq.size() < D) && m_cs);
      if (wen) begin
        chk("address_a", sram_address_a, m_wr);
        chk("data_in_a", sram_data_in_a, pd);
      end
    end
    if (r) begin
      mq.delete();
      m_cs = 0; m_wr = '0; m_rd = '0;
      started = 1;
    end else begin
      ap = p && (mq.size() < D) && m_cs;
      aq = q && (mq.size() > 0) && m_cs;
      ov = p && (mq.size() == D);
      uf = q && (mq.size() == 0);
      pv = aq;
      if (aq) begin ed = mq.pop_front(); m_rd++; end
      if (ap) begin mq.push_back(pd); m_wr++; end
      m_cs = 1;
    end
    #1;
    if (started) begin
      chk("count", count, mq.size());
      chk("full", full, mq.size() == D);
      chk("empty", empty, mq.size() == 0);
      chk("pop_valid", pop_valid, pv);
      chk("overflow", overflow, ov);
      chk("underflow", underflow, uf);
      chk("chip_sel", sram_chip_sel, !r);
      if (pv) chk("pop_data", pop_data, ed);
    end
  end

  task automatic cyc(input logic p, input logic [W-1:0] d, input logic q);
    push = p; push_data = d; pop = q;
    @(negedge clk);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: run exceeded time limit");
    $fatal(1);
  end

  initial begin
    logic [W-1:0] ev;
    reset = 1'b1; push = 1'b0; pop = 1'b0; push_data = '0;
    repeat (3) @(negedge clk);
    chk("rst_count", count, 0);
    chk("rst_empty", empty, 1);
    chk("rst_full", full, 0);
    chk("rst_pop_valid", pop_valid, 0);
    chk("rst_overflow", overflow, 0);
    chk("rst_underflow", underflow, 0);
    chk("rst_chip_sel", sram_chip_sel, 0);
    reset = 1'b0;
    #1 chk("chip_sel_after_reset", sram_chip_sel, 0);
    @(negedge clk);
    chk("chip_sel_back", sram_chip_sel, 1);

    // Scenario 1: three pushes then three pops
    cyc(1, 8'h11, 0); cyc(1, 8'h22, 0); cyc(1, 8'h33, 0);
    chk("s1_count3", count, 3);
    cyc(0, 8'h00, 1); chk("s1_v0", pop_valid, 1); chk("s1_d0", pop_data, 8'h11);
    cyc(0, 8'h00, 1); chk("s1_v1", pop_valid, 1); chk("s1_d1", pop_data, 8'h22);
    cyc(0, 8'h00, 1); chk("s1_v2", pop_valid, 1); chk("s1_d2", pop_data, 8'h33);
    chk("s1_count0", count, 0);
    cyc(0, 8'h00, 0); chk("s1_idle_valid", pop_valid, 0);

    // Scenario 2: fill, overflow, drain
    for (int i = 0; i < 8; i++) cyc(1, 8'hA0 + 8'(i), 0);
    chk("s2_full", full, 1);
    chk("s2_count8", count, 8);
    cyc(1, 8'hAA, 0);
    chk("s2_overflow", overflow, 1);
    chk("s2_count_still8", count, 8);
    cyc(0, 8'h00, 0); chk("s2_overflow_pulse", overflow, 0);
    for (int i = 0; i < 8; i++) begin
      cyc(0, 8'h00, 1);
      chk("s2_drain_data", pop_data, 8'hA0 + 8'(i));
    end
    cyc(0, 8'h00, 0);
    chk("s2_empty", empty, 1);
    chk("s2_no_extra_valid", pop_valid, 0);

    // Scenario 3: pop on empty with simultaneous push
    cyc(1, 8'h5C, 1);
    chk("s3_underflow", underflow, 1);
    chk("s3_no_valid", pop_valid, 0);
    chk("s3_count1", count, 1);
    cyc(0, 8'h00, 1);
    chk("s3_valid", pop_valid, 1);
    chk("s3_data", pop_data, 8'h5C);
    cyc(0, 8'h00, 0);

    // Scenario 4: steady push+pop at count 4, pointers wrap
    for (int i = 0; i < 4; i++) cyc(1, 8'h40 + 8'(i), 0);
    for (int i = 0; i < 10; i++) begin
      cyc(1, 8'h50 + 8'(i), 1);
      ev = (i < 4) ? 8'h40 + 8'(i) : 8'h50 + 8'(i - 4);
      chk("s4_data", pop_data, ev);
      chk("s4_count4", count, 4);
    end

    // Scenario 5: reset on the cycle after an issued pop
    cyc(0, 8'h00, 1);
    chk("s5_valid_before_reset", pop_valid, 1);
    chk("s5_data", pop_data, 8'h56);
    reset = 1'b1;
    cyc(0, 8'h00, 0);
    chk("s5_valid_cleared", pop_valid, 0);
    chk("s5_count0", count, 0);
    chk("s5_empty", empty, 1);
    chk("s5_chip_sel_in_reset", sram_chip_sel, 0);
    reset = 1'b0;
    #1 chk("s5_chip_sel_after", sram_chip_sel, 0);
    @(negedge clk);
    chk("s5_chip_sel_back", sram_chip_sel, 1);
    chk("s5_valid_still0", pop_valid, 0);

    // Operation resumes cleanly after the mid-run reset
    cyc(1, 8'h77, 0);
    cyc(0, 8'h00, 1);
    chk("post_reset_data", pop_data, 8'h77);
    cyc(0, 8'h00, 0);
    @(negedge clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
